// File: rtl/pc_unit.sv
// ----------------------------------------------------------------------------
// pc_unit : program counter with internal next-PC select and run/halt/err FSM.
//           Optional return-address stack enabled by defining PC_RAS_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pc_unit #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] ERR_VEC   = 32'h0000_0080,
  parameter int          RAS_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              PCWre,
  input  logic [1:0]        PCSrc,
  input  logic [ADDR_W-1:0] branchOffset,
  input  logic [25:0]       jumpTarget,
  input  logic [ADDR_W-1:0] regTarget,
  input  logic              halt,
  input  logic              resume,
  input  logic              errClr,
`ifdef PC_RAS_EN
  input  logic              rasPush,
  input  logic              rasPop,
  output logic              rasEmpty,
  output logic              rasFull,
`endif
  output logic [ADDR_W-1:0] addressOut,
  output logic [ADDR_W-1:0] pcPlus4,
  output logic [1:0]        state,
  output logic              addrErr,
  output logic [ADDR_W-1:0] badAddr
);

  localparam logic [1:0] S_RUN  = 2'b00;
  localparam logic [1:0] S_HALT = 2'b01;
  localparam logic [1:0] S_ERR  = 2'b10;

  localparam logic [ADDR_W-1:0] RESET_W = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] ERR_W   = ADDR_W'(ERR_VEC);

  if (ADDR_W < 32 || RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_param_chk
    $error("pc_unit: ADDR_W must be >= 32 and RAS_DEPTH a power of 2 >= 2");
  end

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] bad_q, bad_d;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] reg_tgt;
  logic              is_run;
  logic              commit;

  assign pcPlus4 = pc_q + ADDR_W'(4);
  // Encoding 11 is unreachable; treat it as RUN so the unit can never lock up.
  assign is_run  = (state_q != S_HALT) && (state_q != S_ERR);
  assign commit  = is_run && !halt && PCWre && (next_pc[1:0] == 2'b00);

  always_comb begin
    next_pc = pcPlus4;
    case (PCSrc)
      2'b01:   next_pc = pcPlus4 + {branchOffset[ADDR_W-3:0], 2'b00};
      2'b10:   next_pc = {pcPlus4[ADDR_W-1:28], jumpTarget, 2'b00};
      2'b11:   next_pc = reg_tgt;
      default: next_pc = pcPlus4;
    endcase
  end

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]     sp_q, sp_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic [PW-1:0]     top_idx;
  logic              pop_hit;
  logic              ras_we;
  logic [PW-1:0]     ras_wa;

  assign top_idx  = sp_q - PW'(1);
  assign rasEmpty = (cnt_q == '0);
  assign rasFull  = (cnt_q == (PW+1)'(RAS_DEPTH));
  assign pop_hit  = rasPop && (PCSrc == 2'b11) && !rasEmpty;
  assign reg_tgt  = pop_hit ? ras_mem[top_idx] : regTarget;

  // sp points at the next free slot; when full that slot is the oldest entry.
  always_comb begin
    sp_d   = sp_q;
    cnt_d  = cnt_q;
    ras_we = 1'b0;
    ras_wa = sp_q;
    if (commit) begin
      if (rasPush && pop_hit) begin
        ras_we = 1'b1;
        ras_wa = top_idx;
      end else if (rasPush) begin
        ras_we = 1'b1;
        sp_d   = sp_q + PW'(1);
        cnt_d  = rasFull ? cnt_q : cnt_q + (PW+1)'(1);
      end else if (pop_hit) begin
        sp_d   = top_idx;
        cnt_d  = cnt_q - (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (ras_we) ras_mem[ras_wa] <= pcPlus4;
  end
`else
  assign reg_tgt = regTarget;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_RUN;
      pc_q    <= RESET_W;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bad_d   = bad_q;
    case (state_q)
      S_HALT: if (resume && !halt) state_d = S_RUN;
      S_ERR: begin
        if (errClr) begin
          state_d = S_RUN;
          pc_d    = ERR_W;
        end
      end
      default: begin
        if (halt) begin
          state_d = S_HALT;
        end else if (PCWre && (next_pc[1:0] != 2'b00)) begin
          state_d = S_ERR;
          bad_d   = next_pc;
        end else if (PCWre) begin
          pc_d    = next_pc;
        end
      end
    endcase
  end

  always_comb begin
    addrErr    = (state_q == S_ERR);
    state      = state_q;
    addressOut = pc_q;
    badAddr    = bad_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; RAS section runs when PC_RAS_EN is defined.
`default_nettype none

module tb_pc_unit;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        PCWre;
  logic [1:0]  PCSrc;
  logic [31:0] branchOffset;
  logic [25:0] jumpTarget;
  logic [31:0] regTarget;
  logic        halt, resume, errClr;
  logic [31:0] addressOut, pcPlus4, badAddr;
  logic [1:0]  state;
  logic        addrErr;
`ifdef PC_RAS_EN
  logic        rasPush, rasPop, rasEmpty, rasFull;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  pc_unit dut (
    .CLK(CLK), .RST_N(RST_N), .PCWre(PCWre), .PCSrc(PCSrc),
    .branchOffset(branchOffset), .jumpTarget(jumpTarget), .regTarget(regTarget),
    .halt(halt), .resume(resume), .errClr(errClr),
`ifdef PC_RAS_EN
    .rasPush(rasPush), .rasPop(rasPop), .rasEmpty(rasEmpty), .rasFull(rasFull),
`endif
    .addressOut(addressOut), .pcPlus4(pcPlus4), .state(state),
    .addrErr(addrErr), .badAddr(badAddr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; PCWre = 1'b0; PCSrc = 2'b00; branchOffset = '0;
    jumpTarget = '0; regTarget = '0; halt = 1'b0; resume = 1'b0; errClr = 1'b0;
`ifdef PC_RAS_EN
    rasPush = 1'b0; rasPop = 1'b0;
`endif
    #12;
    chk("rst_pc", addressOut, 32'h0);
    chk("rst_pc4", pcPlus4, 32'h4);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_err", {31'd0, addrErr}, 32'd0);
    chk("rst_bad", badAddr, 32'h0);
    RST_N = 1'b1;

    // sequential stepping, then async reset mid-cycle
    PCWre = 1'b1; PCSrc = 2'b00;
    tick(); chk("seq_1", addressOut, 32'h4);
    tick(); chk("seq_2", addressOut, 32'h8);
    tick(); chk("seq_3", addressOut, 32'hC);
    PCWre = 1'b0;
    #2 RST_N = 1'b0;
    #1 chk("async_rst", addressOut, 32'h0);
    RST_N = 1'b1;

    // branch and jump
    PCWre = 1'b1; PCSrc = 2'b11; regTarget = 32'h100;
    tick(); chk("jr_100", addressOut, 32'h100);
    PCSrc = 2'b01; branchOffset = 32'hFFFF_FFFE;
    tick(); chk("branch_neg", addressOut, 32'hFC);
    PCSrc = 2'b11; regTarget = 32'h1000_0000;
    tick(); chk("jr_hi", addressOut, 32'h1000_0000);
    PCSrc = 2'b10; jumpTarget = 26'h40;
    tick(); chk("jump", addressOut, 32'h1000_0100);
    PCWre = 1'b0;
    tick(); chk("hold", addressOut, 32'h1000_0100);

    // misaligned register target traps
    PCWre = 1'b1; PCSrc = 2'b11; regTarget = 32'h202;
    tick();
    chk("trap_state", {30'd0, state}, 32'd2);
    chk("trap_err", {31'd0, addrErr}, 32'd1);
    chk("trap_bad", badAddr, 32'h202);
    chk("trap_pc", addressOut, 32'h1000_0100);
    PCSrc = 2'b00;
    tick(); chk("err_frozen", addressOut, 32'h1000_0100);
    errClr = 1'b1;
    tick();
    chk("clr_pc", addressOut, 32'h80);
    chk("clr_state", {30'd0, state}, 32'd0);
    chk("clr_err", {31'd0, addrErr}, 32'd0);
    errClr = 1'b0;

    // halt / resume
    PCWre = 1'b1; PCSrc = 2'b00; halt = 1'b1;
    tick();
    chk("halt_pc", addressOut, 32'h80);
    chk("halt_state", {30'd0, state}, 32'd1);
    resume = 1'b1;
    tick();
    chk("halt_res_state", {30'd0, state}, 32'd1);
    chk("halt_res_pc", addressOut, 32'h80);
    halt = 1'b0;
    tick();
    chk("resume_state", {30'd0, state}, 32'd0);
    chk("resume_pc", addressOut, 32'h80);
    resume = 1'b0;
    tick(); chk("run_again", addressOut, 32'h84);

    // wrap at the top of the address space
    PCSrc = 2'b11; regTarget = 32'hFFFF_FFFC;
    tick();
    chk("top_pc", addressOut, 32'hFFFF_FFFC);
    chk("top_pc4", pcPlus4, 32'h0);
    PCSrc = 2'b00;
    tick();
    chk("wrap_pc", addressOut, 32'h0);
    chk("wrap_state", {30'd0, state}, 32'd0);
    chk("wrap_err", {31'd0, addrErr}, 32'd0);

`ifdef PC_RAS_EN
    PCSrc = 2'b11; regTarget = 32'h10;
    tick();
    chk("ras_empty0", {31'd0, rasEmpty}, 32'd1);
    rasPush = 1'b1;
    for (int i = 2; i <= 6; i++) begin
      regTarget = 32'(i * 16);
      tick();
    end
    chk("ras_pc60", addressOut, 32'h60);
    chk("ras_full", {31'd0, rasFull}, 32'd1);
    rasPush = 1'b0; rasPop = 1'b1; regTarget = 32'h300;
    tick(); chk("pop_54", addressOut, 32'h54);
    tick(); chk("pop_44", addressOut, 32'h44);
    tick(); chk("pop_34", addressOut, 32'h34);
    tick(); chk("pop_24", addressOut, 32'h24);
    chk("ras_empty1", {31'd0, rasEmpty}, 32'd1);
    tick(); chk("pop_empty", addressOut, 32'h300);
    rasPop = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
